// File: rtl/single_pkg.sv
// -----------------------------------------------------------------------------
// single_pkg
// Shared definitions for the single-cycle core instruction-fetch stage.
//   NOP_INSTR      : instruction word presented when no live instruction exists
//   PC_IDLE        : PC encoding meaning "no valid PC" (PC-register reset value)
//   fetch_state_e  : fetch FSM encoding (idle / fetching / draining a cancelled fetch)
//   fetch_entry_t  : {instr, pc} pair carried through the skid and output register
// -----------------------------------------------------------------------------
package single_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_IDLE   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Word address of a byte PC; the two low bits are ignored.
  function automatic logic [29:0] pc_word_addr(input logic [31:0] pc);
    return pc[31:2];
  endfunction

endpackage

// File: rtl/single_ifetch_skid.sv
// -----------------------------------------------------------------------------
// single_ifetch_skid
// One-entry {instr, pc} holding buffer for a word that returned while decode was
// stalled with the output register occupied.
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   i_load    in   capture i_entry (takes priority over unload)
//   i_unload  in   entry consumed, buffer becomes empty
//   i_clear   in   discard contents (flush)
//   i_entry   in   {instr, pc} to capture
//   o_valid   out  buffer holds an entry
//   o_entry   out  buffered {instr, pc}
// -----------------------------------------------------------------------------
module single_ifetch_skid
  import single_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_entry <= '{instr: NOP_INSTR, pc: PC_IDLE};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/single_ifetch.sv
// -----------------------------------------------------------------------------
// single_ifetch
// Instruction-fetch stage behind the PC register. Fetches the word at i_pc over a
// req/ack memory handshake, registers {instr, pc} for decode and holds the PC
// register until the fetch retires. i_pc == PC_IDLE means nothing to fetch.
// Ports:
//   clk         in   clock
//   rst         in   synchronous reset, active-high
//   i_pc        in   current PC
//   i_flush     in   branch/jump taken: drop fetched and in-flight words
//   i_stall     in   decode cannot accept a new instruction
//   o_pc_stall  out  PC register must hold
//   imem_req    out  fetch request (held with stable address until ack)
//   imem_addr   out  word address
//   imem_ack    in   request accepted, imem_rdata valid this cycle
//   imem_rdata  in   instruction word
//   o_valid     out  o_instr / o_instr_pc are live
//   o_instr     out  fetched instruction
//   o_instr_pc  out  PC of o_instr
// -----------------------------------------------------------------------------
module single_ifetch
  import single_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  input  logic        i_stall,
  output logic        o_pc_stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc
);

  fetch_state_e r_state, w_state_next;
  logic [29:0]  r_addr;
  logic         r_valid;
  fetch_entry_t r_out;

  logic         w_pc_live;
  logic         w_fetch_req;
  logic         w_ack_fetch;
  logic         w_out_load;
  logic         w_skid_load;
  logic         w_skid_unload;
  logic         w_skid_valid;
  fetch_entry_t w_skid_entry;
  fetch_entry_t w_fetch_entry;

  assign w_pc_live     = (i_pc != PC_IDLE);
  // A full skid blocks new requests, so an accepted fetch always finds it empty.
  assign w_fetch_req   = w_pc_live && !w_skid_valid;
  assign w_ack_fetch   = (r_state == StFetch) && imem_req && imem_ack;
  assign w_out_load    = !r_valid || !i_stall;
  assign w_skid_load   = w_ack_fetch && r_valid && i_stall && !i_flush;
  assign w_skid_unload = w_out_load && w_skid_valid;
  assign w_fetch_entry = '{instr: imem_rdata, pc: i_pc};

  single_ifetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (i_flush),
    .i_entry  (w_fetch_entry),
    .o_valid  (w_skid_valid),
    .o_entry  (w_skid_entry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pc_live) w_state_next = StFetch;
      end
      StFetch: begin
        // A request in flight cannot be withdrawn; park in DRAIN to swallow its ack.
        if (i_flush && imem_req && !imem_ack) begin
          w_state_next = StDrain;
        end else if (!w_pc_live) begin
          w_state_next = StIdle;
        end
      end
      StDrain: begin
        if (imem_ack) w_state_next = StFetch;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_word_addr(i_pc);
    o_pc_stall = 1'b0;
    unique case (r_state)
      StIdle: begin
        imem_req = 1'b0;
      end
      StFetch: begin
        imem_req   = w_fetch_req;
        o_pc_stall = !i_flush && ((w_fetch_req && !imem_ack) || w_skid_valid);
      end
      StDrain: begin
        imem_req   = 1'b1;
        imem_addr  = r_addr;
        o_pc_stall = !i_flush;
      end
      default: begin
        imem_req   = 1'b0;
        o_pc_stall = 1'b0;
      end
    endcase
  end

  // r_addr tracks the address of the request in flight while fetching, so DRAIN
  // can keep presenting it after the PC has moved to the flush target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (r_state == StFetch) begin
      r_addr <= pc_word_addr(i_pc);
    end
  end

  // Output register: skid has priority over fresh memory data.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
      r_out   <= '{instr: NOP_INSTR, pc: PC_IDLE};
    end else if (w_out_load) begin
      if (w_skid_valid) begin
        r_valid <= 1'b1;
        r_out   <= w_skid_entry;
      end else if (w_ack_fetch) begin
        r_valid <= 1'b1;
        r_out   <= w_fetch_entry;
      end else begin
        r_valid <= 1'b0;
        r_out   <= '{instr: NOP_INSTR, pc: PC_IDLE};
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_out.instr;
  assign o_instr_pc = r_out.pc;

endmodule

// File: tb/tb_single_ifetch.sv
module tb_single_ifetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic        clk;
  logic        rst;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_stall;
  logic        o_pc_stall;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;

  logic        ack_zero_wait;
  logic        ack_force;

  int n_checks = 0;
  int n_errors = 0;
  item_t sb[$];

  // Memory model: content is a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hC0DE_0000 + {2'b00, a};
  endfunction

  assign imem_ack   = ack_zero_wait ? imem_req : ack_force;
  assign imem_rdata = mem_word(imem_addr);

  single_ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (i_pc),
    .i_flush    (i_flush),
    .i_stall    (i_stall),
    .o_pc_stall (o_pc_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .o_valid    (o_valid),
    .o_instr    (o_instr),
    .o_instr_pc (o_instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    item_t it;
    it.instr = mem_word(pc[31:2]);
    it.pc    = pc;
    sb.push_back(it);
  endtask

  // Compare a newly loaded output against the head of the scoreboard.
  task automatic sb_check();
    item_t it;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_errors++;
      $error("FAIL sb_unexpected: got pc %h required no instruction", o_instr_pc);
    end
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk32("sb_instr", o_instr, it.instr);
      chk32("sb_pc", o_instr_pc, it.pc);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic fl, input logic st);
    i_pc    = pc;
    i_flush = fl;
    i_stall = st;
    #1;
  endtask

  // Advance one clock; an output present after the edge is new when the register
  // was allowed to load and no flush/reset cleared it.
  task automatic tick();
    logic load_en;
    load_en = (!o_valid || !i_stall) && !i_flush && !rst;
    @(posedge clk);
    #1;
    if (o_valid && load_en) sb_check();
  endtask

  task automatic comb(input string tag, input logic req, input logic [29:0] addr,
                      input logic stall);
    chk1({tag, "_req"}, imem_req, req);
    if (req) chk32({tag, "_addr"}, {2'b00, imem_addr}, {2'b00, addr});
    chk1({tag, "_pc_stall"}, o_pc_stall, stall);
  endtask

  initial begin
    rst = 1'b1;
    ack_zero_wait = 1'b1;
    ack_force = 1'b0;
    drive(32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(32'hFFFF_FFFF, 1'b0, 1'b0);
    chk1("rst_valid", o_valid, 1'b0);
    chk32("rst_instr", o_instr, 32'h0000_0000);
    chk32("rst_instr_pc", o_instr_pc, 32'hFFFF_FFFF);
    comb("rst", 1'b0, 30'h0, 1'b0);

    // 1. Zero-wait memory, one instruction per cycle.
    push(32'h0); push(32'h4); push(32'h8);
    drive(32'h0, 1'b0, 1'b0); comb("t1_idle", 1'b0, 30'h0, 1'b0); tick();
    chk1("t1_c1_valid", o_valid, 1'b0);
    drive(32'h0, 1'b0, 1'b0); comb("t1_f0", 1'b1, 30'h0, 1'b0); tick();
    chk1("t1_c2_valid", o_valid, 1'b1);
    drive(32'h4, 1'b0, 1'b0); comb("t1_f4", 1'b1, 30'h1, 1'b0); tick();
    drive(32'h8, 1'b0, 1'b0); comb("t1_f8", 1'b1, 30'h2, 1'b0); tick();
    chk1("t1_c4_valid", o_valid, 1'b1);
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); comb("t1_end", 1'b0, 30'h0, 1'b0); tick();
    chk1("t1_bubble", o_valid, 1'b0);
    chk32("t1_bubble_instr", o_instr, 32'h0);
    chk32("t1_drained", 32'(sb.size()), 32'd0);

    // 2. Three-cycle ack latency.
    ack_zero_wait = 1'b0;
    drive(32'h10, 1'b0, 1'b0); tick();
    push(32'h10);
    drive(32'h10, 1'b0, 1'b0); comb("t2_w1", 1'b1, 30'h4, 1'b1); tick();
    chk1("t2_w1_valid", o_valid, 1'b0);
    drive(32'h10, 1'b0, 1'b0); comb("t2_w2", 1'b1, 30'h4, 1'b1); tick();
    ack_force = 1'b1;
    drive(32'h10, 1'b0, 1'b0); comb("t2_ack", 1'b1, 30'h4, 1'b0); tick();
    chk1("t2_valid", o_valid, 1'b1);
    ack_force = 1'b0;
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    chk32("t2_drained", 32'(sb.size()), 32'd0);

    // 3. Decode stall fills the skid; words delivered in order afterwards.
    ack_zero_wait = 1'b1;
    push(32'h40); push(32'h44); push(32'h48);
    drive(32'h40, 1'b0, 1'b0); tick();
    drive(32'h40, 1'b0, 1'b0); tick();
    drive(32'h44, 1'b0, 1'b1); comb("t3_to_skid", 1'b1, 30'h11, 1'b0); tick();
    chk32("t3_hold1", o_instr_pc, 32'h40);
    drive(32'h48, 1'b0, 1'b1); comb("t3_skid_full", 1'b0, 30'h0, 1'b1); tick();
    chk32("t3_hold2", o_instr_pc, 32'h40);
    drive(32'h48, 1'b0, 1'b0); comb("t3_unload", 1'b0, 30'h0, 1'b1); tick();
    drive(32'h48, 1'b0, 1'b0); comb("t3_f48", 1'b1, 30'h12, 1'b0); tick();
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    chk32("t3_drained", 32'(sb.size()), 32'd0);

    // 4. Flush while waiting on ack: in-flight 0x20 is drained and dropped.
    ack_zero_wait = 1'b0;
    drive(32'h20, 1'b0, 1'b0); tick();
    drive(32'h20, 1'b0, 1'b0); comb("t4_wait", 1'b1, 30'h8, 1'b1); tick();
    drive(32'h20, 1'b1, 1'b0); comb("t4_flush", 1'b1, 30'h8, 1'b0); tick();
    chk1("t4_flush_valid", o_valid, 1'b0);
    drive(32'h100, 1'b0, 1'b0); comb("t4_drain", 1'b1, 30'h8, 1'b1); tick();
    ack_force = 1'b1;
    drive(32'h100, 1'b0, 1'b0); comb("t4_drain_ack", 1'b1, 30'h8, 1'b1); tick();
    chk1("t4_discard", o_valid, 1'b0);
    ack_force = 1'b0;
    push(32'h100);
    drive(32'h100, 1'b0, 1'b0); comb("t4_target", 1'b1, 30'h40, 1'b1); tick();
    ack_force = 1'b1;
    drive(32'h100, 1'b0, 1'b0); comb("t4_target_ack", 1'b1, 30'h40, 1'b0); tick();
    chk32("t4_pc", o_instr_pc, 32'h100);
    ack_force = 1'b0;
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    chk32("t4_drained", 32'(sb.size()), 32'd0);

    // 4b. Flush coinciding with ack: word dropped, fetching continues directly.
    ack_zero_wait = 1'b1;
    push(32'h200);
    drive(32'h200, 1'b0, 1'b0); tick();
    drive(32'h200, 1'b0, 1'b0); tick();
    drive(32'h204, 1'b1, 1'b0); comb("t4b_flush_ack", 1'b1, 30'h81, 1'b0); tick();
    chk1("t4b_valid", o_valid, 1'b0);
    push(32'h300);
    drive(32'h300, 1'b0, 1'b0); comb("t4b_next", 1'b1, 30'hC0, 1'b0); tick();
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    chk32("t4b_drained", 32'(sb.size()), 32'd0);

    // 5. Reset with a request outstanding and a live output held by stall.
    push(32'h50);
    drive(32'h50, 1'b0, 1'b0); tick();
    drive(32'h50, 1'b0, 1'b0); tick();
    ack_zero_wait = 1'b0;
    drive(32'h54, 1'b0, 1'b1); comb("t5_pending", 1'b1, 30'h15, 1'b1); tick();
    chk1("t5_held", o_valid, 1'b1);
    rst = 1'b1;
    drive(32'h54, 1'b0, 1'b1); tick();
    rst = 1'b0;
    drive(32'hFFFF_FFFF, 1'b0, 1'b0);
    comb("t5_after", 1'b0, 30'h0, 1'b0);
    chk1("t5_valid", o_valid, 1'b0);
    chk32("t5_instr", o_instr, 32'h0);
    chk32("t5_instr_pc", o_instr_pc, 32'hFFFF_FFFF);
    tick();
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); comb("t5_idle", 1'b0, 30'h0, 1'b0); tick();
    chk1("t5_idle_valid", o_valid, 1'b0);
    chk32("t5_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
